// File: rtl/lc4_div_sequencer.sv
// Shared 16-bit restoring divider for LC4 pipes A and B: round-robin accept,
// one quotient bit per cycle, registered result held until the consumer takes it.
module lc4_div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_a_valid,
    input  logic [15:0] i_a_dividend,
    input  logic [15:0] i_a_divisor,
    input  logic [2:0]  i_a_tag,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [15:0] i_b_dividend,
    input  logic [15:0] i_b_divisor,
    input  logic [2:0]  i_b_tag,
    output logic        o_b_ready,
    input  logic        i_kill,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic        o_resp_port,
    output logic [2:0]  o_resp_tag,
    output logic [15:0] o_resp_quotient,
    output logic [15:0] o_resp_remainder
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic        ptr;      // 0 = pipe A preferred, 1 = pipe B preferred
    logic [3:0]  cnt;
    logic [15:0] dvd;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [15:0] dsr;
    logic [15:0] rem;
    logic [2:0]  tag;
    logic        port;

    logic        accept_ok;
    logic        grant_a;
    logic        grant_b;
    logic [15:0] sel_dvd;
    logic [15:0] sel_dsr;
    logic [2:0]  sel_tag;
    logic [15:0] shifted;
    logic        fit;

    always_comb begin
        accept_ok = (state == IDLE) && !i_kill && !rst;
        grant_a   = accept_ok && i_a_valid && (!i_b_valid || !ptr);
        grant_b   = accept_ok && i_b_valid && (!i_a_valid || ptr);
        sel_dvd   = grant_b ? i_b_dividend : i_a_dividend;
        sel_dsr   = grant_b ? i_b_divisor  : i_a_divisor;
        sel_tag   = grant_b ? i_b_tag      : i_a_tag;
        // Partial remainder stays below 2^k after k steps, so the shift never overflows.
        shifted   = {rem[14:0], dvd[15]};
        fit       = (shifted >= dsr);
    end

    assign o_a_ready        = grant_a;
    assign o_b_ready        = grant_b;
    assign o_resp_valid     = (state == DONE);
    assign o_resp_port      = port;
    assign o_resp_tag       = tag;
    assign o_resp_quotient  = dvd;
    assign o_resp_remainder = rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            cnt   <= 4'd0;
            dvd   <= 16'd0;
            dsr   <= 16'd0;
            rem   <= 16'd0;
            tag   <= 3'd0;
            port  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        port <= grant_b;
                        tag  <= sel_tag;
                        dsr  <= sel_dsr;
                        ptr  <= grant_a;
                        rem  <= 16'd0;
                        cnt  <= 4'd0;
                        if (sel_dsr == 16'd0) begin
                            dvd   <= 16'd0;
                            state <= DONE;
                        end else begin
                            dvd   <= sel_dvd;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (i_kill) begin
                        state <= IDLE;
                    end else begin
                        rem <= fit ? (shifted - dsr) : shifted;
                        dvd <= {dvd[14:0], fit};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (i_kill || i_resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc4_div_sequencer.sv
// Bench for lc4_div_sequencer: directed table, corner sequences and random ops
// checked against an arithmetic divide model with a round-robin preference bit.
module tb_lc4_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_a_valid, i_b_valid;
    logic [15:0] i_a_dividend, i_a_divisor, i_b_dividend, i_b_divisor;
    logic [2:0]  i_a_tag, i_b_tag;
    logic        o_a_ready, o_b_ready;
    logic        i_kill;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic        o_resp_port;
    logic [2:0]  o_resp_tag;
    logic [15:0] o_resp_quotient, o_resp_remainder;

    int   checks   = 0;
    int   failures = 0;
    logic model_ptr;
    int   early;

    always #5 clk = ~clk;

    lc4_div_sequencer dut (
        .clk(clk), .rst(rst),
        .i_a_valid(i_a_valid), .i_a_dividend(i_a_dividend), .i_a_divisor(i_a_divisor),
        .i_a_tag(i_a_tag), .o_a_ready(o_a_ready),
        .i_b_valid(i_b_valid), .i_b_dividend(i_b_dividend), .i_b_divisor(i_b_divisor),
        .i_b_tag(i_b_tag), .o_b_ready(o_b_ready),
        .i_kill(i_kill), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_port(o_resp_port), .o_resp_tag(o_resp_tag),
        .o_resp_quotient(o_resp_quotient), .o_resp_remainder(o_resp_remainder)
    );

    typedef struct {
        logic        av;
        logic [15:0] ad, as;
        logic [2:0]  at;
        logic        bv;
        logic [15:0] bd, bs;
        logic [2:0]  bt;
        logic        ep;
        logic [15:0] eq, er;
        logic [2:0]  et;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic set_a(input logic v, input logic [15:0] d, input logic [15:0] s, input logic [2:0] t);
        i_a_valid = v; i_a_dividend = d; i_a_divisor = s; i_a_tag = t;
    endtask

    task automatic set_b(input logic v, input logic [15:0] d, input logic [15:0] s, input logic [2:0] t);
        i_b_valid = v; i_b_dividend = d; i_b_divisor = s; i_b_tag = t;
    endtask

    // Step n cycles, counting any cycle where a response is (wrongly) visible.
    task automatic wait_busy(input int n, output int e);
        e = 0;
        for (int c = 0; c < n; c++) begin
            settle;
            if (o_resp_valid) e++;
            tick;
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [15:0] n, input logic [15:0] d);
        if (d == 16'd0) return 32'd0;
        return {n / d, n % d};
    endfunction

    // Called just after a rising edge with the DUT idle.
    task automatic run_op(input logic av, input logic [15:0] ad, input logic [15:0] as, input logic [2:0] at,
                          input logic bv, input logic [15:0] bd, input logic [15:0] bs, input logic [2:0] bt,
                          input logic ep, input logic [15:0] eq, input logic [15:0] er, input logic [2:0] et,
                          input string nm);
        int lat;
        int exp_lat;
        set_a(av, ad, as, at);
        set_b(bv, bd, bs, bt);
        settle;
        chk({nm, "_grant"}, {30'd0, o_b_ready, o_a_ready}, ep ? 32'd2 : 32'd1);
        exp_lat = ((ep ? bs : as) == 16'd0) ? 1 : 17;
        tick;
        i_a_valid = 1'b0;
        i_b_valid = 1'b0;
        lat = 1;
        settle;
        while (!o_resp_valid && lat < 40) begin
            tick; settle; lat++;
        end
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_qr"}, {o_resp_quotient, o_resp_remainder}, {eq, er});
        chk({nm, "_meta"}, {28'd0, o_resp_port, o_resp_tag}, {28'd0, ep, et});
        i_resp_ready = 1'b1;
        tick;
        i_resp_ready = 1'b0;
        settle;
        chk({nm, "_drop"}, {31'd0, o_resp_valid}, 32'd0);
        model_ptr = !ep;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        av, bv, ep;
        logic [15:0] ad, as, bd, bs;
        logic [2:0]  at, bt;
        logic [31:0] r;

        tbl[0] = '{1'b1, 16'd100,   16'd7,      3'd3, 1'b0, 16'd0,      16'd0, 3'd0, 1'b0, 16'd14,     16'd2,      3'd3};
        tbl[1] = '{1'b0, 16'd0,     16'd0,      3'd0, 1'b1, 16'd1234,   16'd0, 3'd5, 1'b1, 16'd0,      16'd0,      3'd5};
        tbl[2] = '{1'b1, 16'd50,    16'd5,      3'd1, 1'b1, 16'd7,      16'd2, 3'd2, 1'b0, 16'd10,     16'd0,      3'd1};
        tbl[3] = '{1'b1, 16'd1,     16'd1,      3'd0, 1'b1, 16'hFFFF,   16'd1, 3'd6, 1'b1, 16'hFFFF,   16'd0,      3'd6};
        tbl[4] = '{1'b1, 16'hFFFF,  16'hFFFF,   3'd7, 1'b0, 16'd0,      16'd0, 3'd0, 1'b0, 16'd1,      16'd0,      3'd7};
        tbl[5] = '{1'b1, 16'h1234,  16'h8001,   3'd0, 1'b0, 16'd0,      16'd0, 3'd0, 1'b0, 16'd0,      16'h1234,   3'd0};
        tbl[6] = '{1'b1, 16'hFFFF,  16'h8000,   3'd1, 1'b1, 16'd3,      16'd5, 3'd4, 1'b1, 16'd0,      16'd3,      3'd4};
        tbl[7] = '{1'b1, 16'd0,     16'd3,      3'd2, 1'b1, 16'd8,      16'd0, 3'd3, 1'b0, 16'd0,      16'd0,      3'd2};

        i_kill = 1'b0; i_resp_ready = 1'b0; rst = 1'b1;
        set_a(1'b1, 16'hFFFF, 16'h0010, 3'd1);
        set_b(1'b1, 16'd9, 16'd3, 3'd2);
        tick; tick; settle;
        chk("rst_readies", {30'd0, o_b_ready, o_a_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_resp_valid}, 32'd0);
        chk("rst_qr", {o_resp_quotient, o_resp_remainder}, 32'd0);
        chk("rst_meta", {28'd0, o_resp_port, o_resp_tag}, 32'd0);

        // Both pipes valid out of reset: A first, B right after A's response is taken.
        tick; rst = 1'b0; settle;
        chk("arb_c0_grant", {30'd0, o_b_ready, o_a_ready}, 32'd1);
        tick; i_a_valid = 1'b0;
        wait_busy(16, early);
        settle;
        chk("arb_a_early", early, 0);
        chk("arb_a_valid", {31'd0, o_resp_valid}, 32'd1);
        chk("arb_a_qr", {o_resp_quotient, o_resp_remainder}, {16'h0FFF, 16'h000F});
        chk("arb_a_meta", {28'd0, o_resp_port, o_resp_tag}, {28'd0, 1'b0, 3'd1});
        chk("arb_done_readies", {30'd0, o_b_ready, o_a_ready}, 32'd0);
        i_resp_ready = 1'b1;
        tick; i_resp_ready = 1'b0; settle;
        chk("arb_c18_valid", {31'd0, o_resp_valid}, 32'd0);
        chk("arb_c18_grant", {30'd0, o_b_ready, o_a_ready}, 32'd2);
        tick; i_b_valid = 1'b0;
        wait_busy(16, early);
        settle;
        chk("arb_b_early", early, 0);
        chk("arb_b_qr", {o_resp_quotient, o_resp_remainder}, {16'd3, 16'd0});
        chk("arb_b_meta", {28'd0, o_resp_port, o_resp_tag}, {28'd0, 1'b1, 3'd2});
        i_resp_ready = 1'b1;
        tick; i_resp_ready = 1'b0;
        model_ptr = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].av, tbl[i].ad, tbl[i].as, tbl[i].at, tbl[i].bv, tbl[i].bd, tbl[i].bs, tbl[i].bt,
                   tbl[i].ep, tbl[i].eq, tbl[i].er, tbl[i].et, $sformatf("vec%0d", i));

        // Backpressure on 300/7, then a pending A op that gets killed mid-divide.
        set_a(1'b1, 16'd300, 16'd7, 3'd4);
        settle;
        chk("bp_grant", {30'd0, o_b_ready, o_a_ready}, 32'd1);
        tick; i_a_valid = 1'b0;
        wait_busy(16, early);
        chk("bp_early", early, 0);
        for (int c = 17; c <= 21; c++) begin
            if (c == 18) set_a(1'b1, 16'd500, 16'd9, 3'd1);
            settle;
            chk($sformatf("bp_valid_c%0d", c), {31'd0, o_resp_valid}, 32'd1);
            chk($sformatf("bp_qr_c%0d", c), {o_resp_quotient, o_resp_remainder}, {16'd42, 16'd6});
            chk($sformatf("bp_meta_c%0d", c), {28'd0, o_resp_port, o_resp_tag}, {28'd0, 1'b0, 3'd4});
            chk($sformatf("bp_readies_c%0d", c), {30'd0, o_b_ready, o_a_ready}, 32'd0);
            tick;
        end
        i_resp_ready = 1'b1; settle;
        chk("bp_c22_readies", {30'd0, o_b_ready, o_a_ready}, 32'd0);
        tick; i_resp_ready = 1'b0; settle;
        chk("bp_c23_valid", {31'd0, o_resp_valid}, 32'd0);
        chk("bp_c23_grant", {30'd0, o_b_ready, o_a_ready}, 32'd1);
        tick; i_a_valid = 1'b0;
        wait_busy(7, early);
        i_kill = 1'b1;
        set_a(1'b1, 16'd77, 16'd4, 3'd2);
        settle;
        chk("kill_c8_readies", {30'd0, o_b_ready, o_a_ready}, 32'd0);
        tick; i_kill = 1'b0; settle;
        chk("kill_c9_grant", {30'd0, o_b_ready, o_a_ready}, 32'd1);
        tick; i_a_valid = 1'b0;
        wait_busy(16, early);
        settle;
        chk("kill_no_resp", early, 0);
        chk("kill_next_qr", {o_resp_quotient, o_resp_remainder}, {16'd19, 16'd1});
        chk("kill_next_meta", {28'd0, o_resp_port, o_resp_tag}, {28'd0, 1'b0, 3'd2});
        i_resp_ready = 1'b1;
        tick; i_resp_ready = 1'b0;

        // Kill while DONE drops the pending divide-by-zero response.
        set_b(1'b1, 16'd1234, 16'd0, 3'd5);
        settle;
        chk("kdone_grant", {30'd0, o_b_ready, o_a_ready}, 32'd2);
        tick; i_b_valid = 1'b0; settle;
        chk("kdone_valid", {31'd0, o_resp_valid}, 32'd1);
        i_kill = 1'b1;
        tick; i_kill = 1'b0; settle;
        chk("kdone_dropped", {31'd0, o_resp_valid}, 32'd0);
        tick;

        // Reset mid-divide: pointer returns to A even though A was last granted.
        set_a(1'b1, 16'd20, 16'd3, 3'd3);
        settle;
        chk("rstmid_grant", {30'd0, o_b_ready, o_a_ready}, 32'd1);
        tick; i_a_valid = 1'b0;
        wait_busy(4, early);
        rst = 1'b1;
        set_a(1'b1, 16'd40, 16'd6, 3'd1);
        set_b(1'b1, 16'd40, 16'd7, 3'd2);
        settle;
        chk("rstmid_c5_readies", {30'd0, o_b_ready, o_a_ready}, 32'd0);
        tick; rst = 1'b0; settle;
        chk("rstmid_c6_valid", {31'd0, o_resp_valid}, 32'd0);
        chk("rstmid_c6_qr", {o_resp_quotient, o_resp_remainder}, 32'd0);
        chk("rstmid_c6_meta", {28'd0, o_resp_port, o_resp_tag}, 32'd0);
        chk("rstmid_c6_grant", {30'd0, o_b_ready, o_a_ready}, 32'd1);
        tick; i_a_valid = 1'b0; i_b_valid = 1'b0;
        wait_busy(16, early);
        settle;
        chk("rstmid_early", early, 0);
        chk("rstmid_qr", {o_resp_quotient, o_resp_remainder}, {16'd6, 16'd4});
        chk("rstmid_meta", {28'd0, o_resp_port, o_resp_tag}, {28'd0, 1'b0, 3'd1});
        i_resp_ready = 1'b1;
        tick; i_resp_ready = 1'b0;
        model_ptr = 1'b1;

        for (int i = 0; i < 30; i++) begin
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            if (!av && !bv) av = 1'b1;
            ad = 16'($urandom);
            bd = 16'($urandom);
            as = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 24));
            bs = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 24));
            at = 3'($urandom);
            bt = 3'($urandom);
            ep = (av && bv) ? model_ptr : bv;
            r  = ep ? ref_div(bd, bs) : ref_div(ad, as);
            run_op(av, ad, as, at, bv, bd, bs, bt, ep, r[31:16], r[15:0], ep ? bt : at,
                   $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
